// File: rtl/uart_rx_deserializer_if.sv
// Serial line plus received-byte outputs of the UART receive path.
// master drives the line and consumes bytes; slave is the deserializer.
interface uart_rx_deserializer_if;
  logic       serial_dat_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    output serial_dat_in,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );

  modport slave (
    input  serial_dat_in,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit start validation, centre sampling,
// stop-bit check with one-cycle valid / framing-error pulses.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned HALF_BIT     = 217,
  parameter int unsigned CNT_WIDTH    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_deserializer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_WIDTH-1:0] HALF_TC = CNT_WIDTH'(HALF_BIT - 1);
  localparam logic [CNT_WIDTH-1:0] BIT_TC  = CNT_WIDTH'(CLKS_PER_BIT - 1);

  logic                 sync1_q, rx_s_q;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.serial_dat_in;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  // Counter is cleared at every sample point and state change; no free-running tick.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_WIDTH'(1);
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_TC) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_TC) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_TC) begin
          cnt_d = '0;
          if (rx_s_q) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK_WAIT;
          end
        end
      end
      BRK_WAIT: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule
